// File: rtl/spi_ram_arbiter.sv
// Multi-port SPI slave hub: per-port opcode FSM, shared mailboxes and a sticky
// round-robin grant to one serial RAM bus with registered pin passthrough.
module spi_ram_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] spi_nss,
  input  logic [NUM_PORTS-1:0] spi_sck,
  input  logic [NUM_PORTS-1:0] spi_mosi,
  output logic [NUM_PORTS-1:0] spi_miso,
  output logic                 ram_nss,
  output logic                 ram_sck,
  output logic                 ram_mosi,
  input  logic                 ram_miso,
  output logic [NUM_PORTS-1:0] ram_grant
);
  // state     | meaning
  // ST_IDLE   | nss high, port inactive
  // ST_OPCODE | receiving the opcode byte
  // ST_STATUS | returning {pending, granted} every byte
  // ST_WMBOX  | each byte overwrites own mailbox
  // ST_RIDX   | receiving mailbox index
  // ST_RDATA  | returning mailbox[index] every byte
  // ST_REQ    | request issued, returns 0
  // ST_REL    | release issued, returns 0
  // ST_ACCESS | RAM passthrough when granted
  // ST_IGNORE | unknown opcode, miso 0 until nss rises
  typedef enum logic [3:0] {
    ST_IDLE, ST_OPCODE, ST_STATUS, ST_WMBOX, ST_RIDX,
    ST_RDATA, ST_REQ, ST_REL, ST_ACCESS, ST_IGNORE
  } state_t;

  localparam int CW  = $clog2(DATA_WIDTH);
  localparam int NMB = 2**IDX_WIDTH;
  localparam logic [DATA_WIDTH-1:0] OP_STATUS = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] OP_WMBOX  = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] OP_RMBOX  = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] OP_REQ    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] OP_REL    = DATA_WIDTH'(5);
  localparam logic [DATA_WIDTH-1:0] OP_ACCESS = DATA_WIDTH'(6);

  logic [NUM_PORTS-1:0]  r_nss_s1, r_nss_s2, r_sck_s1, r_sck_s2, r_sck_q;
  logic [NUM_PORTS-1:0]  r_mosi_s1, r_mosi_s2;
  logic [NUM_PORTS-1:0]  r_miso, r_pending, r_grant, r_idx_ok;
  logic [IDX_WIDTH-1:0]  r_last;
  state_t                r_state [NUM_PORTS];
  logic [CW-1:0]         r_cnt   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_rx    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_tx    [NUM_PORTS];
  logic [IDX_WIDTH-1:0]  r_idx   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_mbox  [NMB];
  logic                  r_ram_nss, r_ram_sck, r_ram_mosi;

  state_t                w_state_nxt [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_resp      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_rise, w_fall, w_done, w_req, w_rel, w_wr, w_idx_ld, w_access;
  logic [IDX_WIDTH-1:0]  w_win;
  logic                  w_win_vld, w_ram_act;

  assign w_rise    = r_sck_s2 & ~r_sck_q;
  assign w_fall    = ~r_sck_s2 & r_sck_q;
  assign w_ram_act = |(r_grant & w_access);

  always_comb begin
    w_done   = '0;
    w_req    = '0;
    w_rel    = '0;
    w_wr     = '0;
    w_idx_ld = '0;
    w_access = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_state_nxt[p] = r_state[p];
      w_resp[p]      = '0;
      w_done[p]      = w_fall[p] && (r_cnt[p] == CW'(DATA_WIDTH-1));
      w_access[p]    = (r_state[p] == ST_ACCESS);
      if (r_nss_s2[p]) begin
        w_state_nxt[p] = ST_IDLE;
      end else begin
        case (r_state[p])
          ST_IDLE: w_state_nxt[p] = ST_OPCODE;
          ST_OPCODE: if (w_done[p]) begin
            case (r_rx[p])
              OP_STATUS: begin
                w_state_nxt[p] = ST_STATUS;
                w_resp[p] = {{(DATA_WIDTH-2){1'b0}}, r_pending[p], r_grant[p]};
              end
              OP_WMBOX:  w_state_nxt[p] = ST_WMBOX;
              OP_RMBOX:  w_state_nxt[p] = ST_RIDX;
              OP_REQ:    begin w_state_nxt[p] = ST_REQ; w_req[p] = 1'b1; end
              OP_REL:    begin w_state_nxt[p] = ST_REL; w_rel[p] = 1'b1; end
              OP_ACCESS: w_state_nxt[p] = ST_ACCESS;
              default:   w_state_nxt[p] = ST_IGNORE;
            endcase
          end
          ST_STATUS: if (w_done[p])
            w_resp[p] = {{(DATA_WIDTH-2){1'b0}}, r_pending[p], r_grant[p]};
          ST_WMBOX: w_wr[p] = w_done[p];
          ST_RIDX: if (w_done[p]) begin
            w_state_nxt[p] = ST_RDATA;
            w_idx_ld[p]    = 1'b1;
            if (r_rx[p] < DATA_WIDTH'(NUM_PORTS)) w_resp[p] = r_mbox[r_rx[p][IDX_WIDTH-1:0]];
          end
          ST_RDATA: if (w_done[p] && r_idx_ok[p]) w_resp[p] = r_mbox[r_idx[p]];
          default: ;
        endcase
      end
    end
  end

  // Ports above last_grant take priority; the second loop overrides the first.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    if (r_grant == '0) begin
      for (int i = NUM_PORTS-1; i >= 0; i--)
        if (r_pending[i] && (IDX_WIDTH'(i) <= r_last)) begin
          w_win = IDX_WIDTH'(i); w_win_vld = 1'b1;
        end
      for (int i = NUM_PORTS-1; i >= 0; i--)
        if (r_pending[i] && (IDX_WIDTH'(i) > r_last)) begin
          w_win = IDX_WIDTH'(i); w_win_vld = 1'b1;
        end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nss_s1 <= '1; r_nss_s2 <= '1;
      r_sck_s1 <= '0; r_sck_s2 <= '0; r_sck_q <= '0;
      r_mosi_s1 <= '0; r_mosi_s2 <= '0;
      r_miso <= '0; r_pending <= '0; r_grant <= '0; r_idx_ok <= '0;
      r_last <= IDX_WIDTH'(NUM_PORTS-1);
      r_ram_nss <= 1'b1; r_ram_sck <= 1'b0; r_ram_mosi <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_state[p] <= ST_IDLE; r_cnt[p] <= '0; r_rx[p] <= '0;
        r_tx[p] <= '0; r_idx[p] <= '0;
      end
      for (int i = 0; i < NMB; i++) r_mbox[i] <= '0;
    end else begin
      r_nss_s1 <= spi_nss;   r_nss_s2 <= r_nss_s1;
      r_sck_s1 <= spi_sck;   r_sck_s2 <= r_sck_s1;   r_sck_q <= r_sck_s2;
      r_mosi_s1 <= spi_mosi; r_mosi_s2 <= r_mosi_s1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_state[p] <= w_state_nxt[p];
        if (r_nss_s2[p]) begin
          r_cnt[p] <= '0;
          r_tx[p]  <= '0;
          r_miso[p] <= 1'b0;
        end else begin
          if (w_rise[p]) r_rx[p] <= {r_mosi_s2[p], r_rx[p][DATA_WIDTH-1:1]};
          if (w_fall[p]) begin
            r_cnt[p] <= w_done[p] ? '0 : r_cnt[p] + 1'b1;
            r_tx[p]  <= w_done[p] ? w_resp[p] : (r_tx[p] >> 1);
          end
          if (w_access[p]) r_miso[p] <= r_grant[p] & ram_miso;
          else             r_miso[p] <= r_tx[p][0];
        end
        if (w_wr[p]) r_mbox[p] <= r_rx[p];
        if (w_idx_ld[p]) begin
          r_idx[p]    <= r_rx[p][IDX_WIDTH-1:0];
          r_idx_ok[p] <= (r_rx[p] < DATA_WIDTH'(NUM_PORTS));
        end
        if (w_req[p] && !r_grant[p]) r_pending[p] <= 1'b1;
        if (w_rel[p] && !r_grant[p]) r_pending[p] <= 1'b0;
        if (w_rel[p] &&  r_grant[p]) r_grant[p]   <= 1'b0;
        if (w_win_vld && (w_win == IDX_WIDTH'(p))) begin
          r_pending[p] <= 1'b0;
          r_grant[p]   <= 1'b1;
        end
      end
      if (w_win_vld) r_last <= w_win;
      if (w_ram_act) begin
        r_ram_nss  <= |(r_grant & r_nss_s2);
        r_ram_sck  <= |(r_grant & r_sck_s2);
        r_ram_mosi <= |(r_grant & r_mosi_s2);
      end else begin
        r_ram_nss  <= 1'b1;
        r_ram_sck  <= 1'b0;
        r_ram_mosi <= 1'b0;
      end
    end
  end

  assign spi_miso  = r_miso;
  assign ram_grant = r_grant;
  assign ram_nss   = r_ram_nss;
  assign ram_sck   = r_ram_sck;
  assign ram_mosi  = r_ram_mosi;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a vector table of SPI transactions plus
// hand sequences for arbitration, RAM passthrough and mid-transfer reset.
module tb_spi_ram_arbiter;
  localparam int NP = 2;

  typedef struct packed {
    logic [0:0]  port;
    logic [1:0]  n;
    logic [23:0] tx;
    logic [23:0] ex;
    logic [2:0]  chk;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] spi_nss = '1, spi_sck = '0, spi_mosi = '0;
  logic [NP-1:0] spi_miso, ram_grant;
  logic          ram_nss, ram_sck, ram_mosi;
  logic          ram_miso = 1'b0;

  int n_pass = 0, n_total = 0;
  int rise_cnt = 0, mm_cnt = 0, nss_low_cnt = 0;
  logic win = 1'b0;
  logic ram_sck_q = 1'b0;
  logic [2:0] h_sck = '0, h_mosi = '0;

  spi_ram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(8), .IDX_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_nss(spi_nss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .ram_nss(ram_nss), .ram_sck(ram_sck), .ram_mosi(ram_mosi), .ram_miso(ram_miso),
    .ram_grant(ram_grant)
  );

  always #5 clk = ~clk;

  // Port 1 input history; h[2] is what the RAM pins should show now.
  always @(posedge clk) begin
    h_sck  <= {h_sck[1:0], spi_sck[1]};
    h_mosi <= {h_mosi[1:0], spi_mosi[1]};
  end

  always @(negedge clk) begin
    if (win && (ram_sck !== h_sck[2] || ram_mosi !== h_mosi[2])) mm_cnt <= mm_cnt + 1;
    if (ram_sck && !ram_sck_q) rise_cnt <= rise_cnt + 1;
    if (!ram_nss) nss_low_cnt <= nss_low_cnt + 1;
    ram_sck_q <= ram_sck;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic spi_start(input int p);
    @(negedge clk);
    spi_nss[p] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_byte(input int p, input logic [7:0] tx, input logic [7:0] rm,
                          output logic [7:0] rx);
    for (int i = 0; i < 8; i++) begin
      spi_mosi[p] = tx[i];
      ram_miso    = rm[i];
      repeat (8) @(negedge clk);
      rx[i] = spi_miso[p];
      spi_sck[p] = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck[p] = 1'b0;
    end
  endtask

  task automatic spi_stop(input int p);
    repeat (6) @(negedge clk);
    spi_nss[p]  = 1'b1;
    spi_mosi[p] = 1'b0;
    ram_miso    = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic apply(input string tag, input vec_t v);
    logic [7:0] rx;
    spi_start(int'(v.port));
    for (int b = 0; b < int'(v.n); b++) begin
      spi_byte(int'(v.port), v.tx[8*b +: 8], 8'h00, rx);
      if (v.chk[b]) check($sformatf("%s byte%0d", tag, b), {24'h0, rx}, {24'h0, v.ex[8*b +: 8]});
    end
    spi_stop(int'(v.port));
  endtask

  initial begin
    vec_t       vecs [11];
    vec_t       va, vb;
    logic [7:0] rx;
    logic [39:0] acc;
    logic       found;
    int s_r, s_m, s_l;

    vecs[0]  = '{port:1'd0, n:2'd2, tx:24'h000001, ex:24'h000000, chk:3'b011};
    vecs[1]  = '{port:1'd0, n:2'd2, tx:24'h00A502, ex:24'h000000, chk:3'b011};
    vecs[2]  = '{port:1'd1, n:2'd3, tx:24'h000003, ex:24'hA50000, chk:3'b111};
    vecs[3]  = '{port:1'd1, n:2'd3, tx:24'h000503, ex:24'h000000, chk:3'b111};
    vecs[4]  = '{port:1'd1, n:2'd2, tx:24'h003C02, ex:24'h000000, chk:3'b011};
    vecs[5]  = '{port:1'd0, n:2'd3, tx:24'h000103, ex:24'h3C0000, chk:3'b111};
    vecs[6]  = '{port:1'd0, n:2'd3, tx:24'h221102, ex:24'h000000, chk:3'b111};
    vecs[7]  = '{port:1'd1, n:2'd3, tx:24'h000003, ex:24'h220000, chk:3'b111};
    vecs[8]  = '{port:1'd1, n:2'd3, tx:24'hAA55FF, ex:24'h000000, chk:3'b111};
    vecs[9]  = '{port:1'd1, n:2'd2, tx:24'h000001, ex:24'h000000, chk:3'b011};
    vecs[10] = '{port:1'd0, n:2'd3, tx:24'h000703, ex:24'h000000, chk:3'b111};

    repeat (4) @(negedge clk);
    check("reset spi_miso", {30'h0, spi_miso}, 0);
    check("reset ram_nss", {31'h0, ram_nss}, 1);
    check("reset ram_sck", {31'h0, ram_sck}, 0);
    check("reset ram_mosi", {31'h0, ram_mosi}, 0);
    check("reset ram_grant", {30'h0, ram_grant}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: port 0 wins first after reset.
    va = '{port:1'd0, n:2'd1, tx:24'h000004, ex:24'h0, chk:3'b001};
    vb = '{port:1'd1, n:2'd1, tx:24'h000004, ex:24'h0, chk:3'b001};
    fork
      apply("req p0", va);
      apply("req p1", vb);
    join
    check("grant after dual request", {30'h0, ram_grant}, 2'b01);
    apply("status p1 pending", '{port:1'd1, n:2'd2, tx:24'h000001, ex:24'h000200, chk:3'b010});
    apply("status p0 granted", '{port:1'd0, n:2'd2, tx:24'h000001, ex:24'h000100, chk:3'b010});

    spi_start(0);
    spi_byte(0, 8'h05, 8'h00, rx);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (ram_grant == 2'b00) found = 1'b1;
    end
    check("release clears grant", {31'h0, found}, 1);
    @(negedge clk);
    check("regrant one clk after release", {30'h0, ram_grant}, 2'b10);
    spi_stop(0);

    // Granted port 1 RAM passthrough.
    acc = 40'h00_00_10_00_03;
    s_r = rise_cnt; s_m = mm_cnt; s_l = nss_low_cnt;
    spi_start(1);
    spi_byte(1, 8'h06, 8'h00, rx);
    check("access opcode miso", {24'h0, rx}, 0);
    repeat (4) @(negedge clk);
    win = 1'b1;
    for (int b = 0; b < 5; b++) begin
      spi_byte(1, acc[8*b +: 8], (b == 4) ? 8'h3C : 8'h00, rx);
      check($sformatf("access miso byte%0d", b), {24'h0, rx}, (b == 4) ? 32'h3C : 32'h0);
    end
    win = 1'b0;
    spi_stop(1);
    check("ram_sck rises", rise_cnt - s_r, 40);
    check("passthrough mismatches", mm_cnt - s_m, 0);
    check("ram_nss asserted during access", {31'h0, nss_low_cnt != s_l}, 1);
    check("ram_nss idle after nss rise", {31'h0, ram_nss}, 1);
    check("grant retained after access", {30'h0, ram_grant}, 2'b10);

    // Ungranted port 0 access must leave the RAM bus idle.
    s_r = rise_cnt; s_l = nss_low_cnt;
    spi_start(0);
    spi_byte(0, 8'h06, 8'hFF, rx);
    check("ungranted opcode miso", {24'h0, rx}, 0);
    spi_byte(0, 8'h5A, 8'hFF, rx);
    check("ungranted miso byte0", {24'h0, rx}, 0);
    spi_byte(0, 8'hC3, 8'hFF, rx);
    check("ungranted miso byte1", {24'h0, rx}, 0);
    spi_stop(0);
    check("ungranted ram_sck rises", rise_cnt - s_r, 0);
    check("ungranted ram_nss low cycles", nss_low_cnt - s_l, 0);

    apply("unknown op", '{port:1'd1, n:2'd2, tx:24'h0055FF, ex:24'h0, chk:3'b011});
    apply("status after unknown", '{port:1'd1, n:2'd2, tx:24'h000001, ex:24'h000100, chk:3'b011});

    // Reset in the middle of an access byte.
    spi_start(1);
    spi_byte(1, 8'h06, 8'h00, rx);
    repeat (8) @(negedge clk);
    spi_mosi[1] = 1'b1;
    spi_sck[1]  = 1'b1;
    repeat (8) @(negedge clk);
    check("mid access ram_nss low", {31'h0, ram_nss}, 0);
    check("mid access ram_sck high", {31'h0, ram_sck}, 1);
    reset_n = 1'b0;
    #1;
    check("async reset ram_nss", {31'h0, ram_nss}, 1);
    check("async reset ram_sck", {31'h0, ram_sck}, 0);
    check("async reset ram_grant", {30'h0, ram_grant}, 0);
    check("async reset spi_miso", {30'h0, spi_miso}, 0);
    spi_sck  = '0;
    spi_mosi = '0;
    spi_nss  = '1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    apply("mbox cleared by reset", '{port:1'd1, n:2'd3, tx:24'h000003, ex:24'h0, chk:3'b100});
    apply("status cleared by reset", '{port:1'd1, n:2'd2, tx:24'h000001, ex:24'h0, chk:3'b010});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
